// File: rtl/uart_types_pkg.sv
// Shared types and constants for the UART interrupt controller.
// Holds the IIR code enum, the THRE FSM states and the character-timeout limit helper.
package uart_types_pkg;

  typedef enum logic [3:0] {
    IIR_NONE = 4'b0001,
    IIR_RLS  = 4'b0110,
    IIR_RDA  = 4'b0100,
    IIR_CTI  = 4'b1100,
    IIR_THRE = 4'b0010
  } iir_id_t;

  typedef enum logic [1:0] {
    T_BUSY = 2'd0,
    T_PEND = 2'd1,
    T_ACK  = 2'd2
  } thre_state_t;

  localparam int CHAR_TIMEOUT_MULT = 64;

  // Bits per frame = start + stop + (5+wls) data + parity + extra stop; 4 chars x 16 ticks.
  function automatic logic [9:0] char_timeout_limit(input logic [1:0] wls,
                                                    input logic pen,
                                                    input logic stb);
    logic [9:0] frame_bits;
    frame_bits = 10'd7 + {8'd0, wls} + {9'd0, pen} + {9'd0, stb};
    return frame_bits * 10'(CHAR_TIMEOUT_MULT);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter: counts baud ticks while the rx FIFO holds idle data.
// Saturates at the limit with the flag held until the next clear.
module uart_rx_timeout
  import uart_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       clear,
  input  logic [9:0] limit,
  output logic       timeout,
  output logic       timeout_next
);

  logic [9:0] cnt_reg;
  logic [9:0] cnt_next;
  logic       timeout_reg;

  // Clear has priority so a push/pop on the terminal tick still restarts the count.
  always_comb begin
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    if (clear) begin
      cnt_next     = 10'd0;
      timeout_next = 1'b0;
    end else if (!timeout_reg && baud_pulse) begin
      cnt_next = cnt_reg + 10'd1;
      if (cnt_next >= limit) timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= 10'd0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;

endmodule

// File: rtl/uart_int_ctrl.sv
// UART interrupt prioritiser: sticky line-status errors, THRE FSM, optional char timeout.
// Character timeout (CTI) is built only when UART_CHAR_TIMEOUT_EN is defined.
module uart_int_ctrl
  import uart_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [2:0] ier_i,
  input  logic       rx_oe_i,
  input  logic       rx_pe_i,
  input  logic       rx_fe_i,
  input  logic       rx_bi_i,
  input  logic       rx_fifo_empty_i,
  input  logic       rx_trig_i,
  input  logic       rx_push_i,
  input  logic       rx_pop_i,
  input  logic       tx_fifo_empty_i,
  input  logic       thr_wr_i,
  input  logic       iir_rd_i,
  input  logic       lsr_rd_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       stb_i,
  output logic [3:0] iir_o,
  output logic       intr_o,
  output logic [3:0] lsr_err_o,
  output logic       timeout_o
);

  logic [3:0]  lsr_err_reg;
  logic [3:0]  lsr_err_next;
  thre_state_t thre_reg;
  thre_state_t thre_next;
  iir_id_t     iir_reg;
  iir_id_t     iir_next;
  logic        intr_reg;
  logic        etbei_reg;
  logic        etbei_rise;
  logic        timeout_now;
  logic        timeout_next;

  // New error pulses are OR-ed in after the read clear, so a set wins over a clear.
  always_comb begin
    lsr_err_next = lsr_rd_i ? 4'b0000 : lsr_err_reg;
    lsr_err_next = lsr_err_next | {rx_bi_i, rx_fe_i, rx_pe_i, rx_oe_i};
  end

  assign etbei_rise = ier_i[1] & ~etbei_reg;

  always_comb begin
    thre_next = thre_reg;
    case (thre_reg)
      T_BUSY: if (tx_fifo_empty_i) thre_next = T_PEND;
      T_PEND: begin
        if (!tx_fifo_empty_i) thre_next = T_BUSY;
        else if (thr_wr_i || (iir_rd_i && iir_reg == IIR_THRE)) thre_next = T_ACK;
      end
      T_ACK: begin
        if (!tx_fifo_empty_i) thre_next = T_BUSY;
        else if (etbei_rise) thre_next = T_PEND;
      end
      default: thre_next = T_BUSY;
    endcase
  end

`ifdef UART_CHAR_TIMEOUT_EN
  uart_rx_timeout u_rx_timeout (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse   (baud_pulse),
    .clear        (rx_push_i | rx_pop_i | rx_fifo_empty_i),
    .limit        (char_timeout_limit(wls_i, pen_i, stb_i)),
    .timeout      (timeout_now),
    .timeout_next (timeout_next)
  );
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{baud_pulse, wls_i, pen_i, stb_i,
                                   rx_push_i, rx_pop_i, rx_fifo_empty_i};
  assign timeout_now  = 1'b0;
  assign timeout_next = 1'b0;
`endif

  // Priority is resolved from next-cycle source state so iir_o moves with its source.
  always_comb begin
    iir_next = IIR_NONE;
    if (ier_i[2] && |lsr_err_next)              iir_next = IIR_RLS;
    else if (ier_i[0] && rx_trig_i)             iir_next = IIR_RDA;
    else if (ier_i[0] && timeout_next)          iir_next = IIR_CTI;
    else if (ier_i[1] && thre_next == T_PEND)   iir_next = IIR_THRE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsr_err_reg <= 4'b0000;
      thre_reg    <= T_BUSY;
      iir_reg     <= IIR_NONE;
      intr_reg    <= 1'b0;
      etbei_reg   <= 1'b0;
    end else begin
      lsr_err_reg <= lsr_err_next;
      thre_reg    <= thre_next;
      iir_reg     <= iir_next;
      intr_reg    <= ~iir_next[0];
      etbei_reg   <= ier_i[1];
    end
  end

  assign iir_o     = iir_reg;
  assign intr_o    = intr_reg;
  assign lsr_err_o = lsr_err_reg;
  assign timeout_o = timeout_now;

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Directed self-checking bench for uart_int_ctrl; CTI scenarios run when
// UART_CHAR_TIMEOUT_EN is defined, otherwise the disabled behaviour is checked.
module tb_uart_int_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_pulse = 1'b0;
  logic [2:0] ier_i = 3'b000;
  logic       rx_oe_i = 1'b0, rx_pe_i = 1'b0, rx_fe_i = 1'b0, rx_bi_i = 1'b0;
  logic       rx_fifo_empty_i = 1'b1, rx_trig_i = 1'b0;
  logic       rx_push_i = 1'b0, rx_pop_i = 1'b0;
  logic       tx_fifo_empty_i = 1'b0, thr_wr_i = 1'b0, iir_rd_i = 1'b0, lsr_rd_i = 1'b0;
  logic [1:0] wls_i = 2'b11;
  logic       pen_i = 1'b0, stb_i = 1'b0;
  logic [3:0] iir_o;
  logic       intr_o;
  logic [3:0] lsr_err_o;
  logic       timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_int_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .baud_pulse      (baud_pulse),
    .ier_i           (ier_i),
    .rx_oe_i         (rx_oe_i),
    .rx_pe_i         (rx_pe_i),
    .rx_fe_i         (rx_fe_i),
    .rx_bi_i         (rx_bi_i),
    .rx_fifo_empty_i (rx_fifo_empty_i),
    .rx_trig_i       (rx_trig_i),
    .rx_push_i       (rx_push_i),
    .rx_pop_i        (rx_pop_i),
    .tx_fifo_empty_i (tx_fifo_empty_i),
    .thr_wr_i        (thr_wr_i),
    .iir_rd_i        (iir_rd_i),
    .lsr_rd_i        (lsr_rd_i),
    .wls_i           (wls_i),
    .pen_i           (pen_i),
    .stb_i           (stb_i),
    .iir_o           (iir_o),
    .intr_o          (intr_o),
    .lsr_err_o       (lsr_err_o),
    .timeout_o       (timeout_o)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic baud_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      baud_pulse = 1'b1; tick();
      baud_pulse = 1'b0; tick();
    end
  endtask

  task automatic chk_iir(input string name, input logic [3:0] exp);
    // Not a shared comparison helper for all signals: iir/intr pair check per transaction.
    n_checks++;
    if (iir_o !== exp || intr_o !== ~exp[0]) begin
      n_fail++;
      $display("FAIL %s: iir_o=%b intr_o=%b, required iir_o=%b intr_o=%b",
               name, iir_o, intr_o, exp, ~exp[0]);
    end else $display("ok   %s: iir_o=%b intr_o=%b", name, iir_o, intr_o);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
    n_checks++;
    if ({iir_o, intr_o, lsr_err_o, timeout_o} !== {4'b0001, 1'b0, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: iir=%b intr=%b lsr=%b to=%b, required 0001 0 0000 0",
               iir_o, intr_o, lsr_err_o, timeout_o);
    end else $display("ok   reset values");
    tick();
    chk_iir("reset_idle", 4'b0001);
  endtask

  task automatic test_rls();
    ier_i = 3'b111; tick();
    rx_fe_i = 1'b1; tick(); rx_fe_i = 1'b0;
    chk_iir("rls_fe", 4'b0110);
    n_checks++;
    if (lsr_err_o !== 4'b0100) begin
      n_fail++; $display("FAIL rls_fe_lsr: lsr_err_o=%b required 0100", lsr_err_o);
    end else $display("ok   rls_fe_lsr: lsr_err_o=%b", lsr_err_o);
    lsr_rd_i = 1'b1; tick(); lsr_rd_i = 1'b0;
    chk_iir("rls_cleared", 4'b0001);
    n_checks++;
    if (lsr_err_o !== 4'b0000) begin
      n_fail++; $display("FAIL rls_clr_lsr: lsr_err_o=%b required 0000", lsr_err_o);
    end else $display("ok   rls_clr_lsr: lsr_err_o=%b", lsr_err_o);
    ier_i = 3'b011;
    rx_bi_i = 1'b1; tick(); rx_bi_i = 1'b0;
    chk_iir("rls_masked", 4'b0001);
    n_checks++;
    if (lsr_err_o !== 4'b1000) begin
      n_fail++; $display("FAIL bi_lsr: lsr_err_o=%b required 1000", lsr_err_o);
    end else $display("ok   bi_lsr: lsr_err_o=%b", lsr_err_o);
    ier_i = 3'b111; tick();
    chk_iir("rls_unmasked", 4'b0110);
    lsr_rd_i = 1'b1; tick(); lsr_rd_i = 1'b0;
  endtask

  task automatic test_rls_over_rda();
    rx_oe_i = 1'b1; tick(); rx_oe_i = 1'b0;
    chk_iir("oe_rls", 4'b0110);
    rx_trig_i = 1'b1; tick();
    chk_iir("rls_over_rda", 4'b0110);
    lsr_rd_i = 1'b1; tick(); lsr_rd_i = 1'b0;
    chk_iir("rda_after_lsr", 4'b0100);
    ier_i = 3'b110; tick();
    chk_iir("rda_masked", 4'b0001);
    ier_i = 3'b111; tick();
    rx_trig_i = 1'b0; tick();
    chk_iir("rda_not_sticky", 4'b0001);
  endtask

  task automatic test_set_wins();
    rx_oe_i = 1'b1; tick(); rx_oe_i = 1'b0;
    rx_pe_i = 1'b1; lsr_rd_i = 1'b1; tick(); rx_pe_i = 1'b0; lsr_rd_i = 1'b0;
    n_checks++;
    if (lsr_err_o !== 4'b0010) begin
      n_fail++; $display("FAIL set_wins: lsr_err_o=%b required 0010", lsr_err_o);
    end else $display("ok   set_wins: lsr_err_o=%b", lsr_err_o);
    chk_iir("set_wins_iir", 4'b0110);
    lsr_rd_i = 1'b1; tick(); lsr_rd_i = 1'b0;
    chk_iir("set_wins_clear", 4'b0001);
  endtask

  task automatic test_thre();
    tx_fifo_empty_i = 1'b1; tick();
    chk_iir("thre_raise", 4'b0010);
    iir_rd_i = 1'b1; tick(); iir_rd_i = 1'b0;
    chk_iir("thre_iir_ack", 4'b0001);
    tick(2);
    chk_iir("thre_ack_hold", 4'b0001);
    thr_wr_i = 1'b1; tick(); thr_wr_i = 1'b0;
    tx_fifo_empty_i = 1'b0; tick();
    chk_iir("thre_busy", 4'b0001);
    tx_fifo_empty_i = 1'b1; tick();
    chk_iir("thre_reraise", 4'b0010);
    // A read while RLS is shown must not acknowledge THRE.
    rx_fe_i = 1'b1; tick(); rx_fe_i = 1'b0;
    chk_iir("thre_hidden_by_rls", 4'b0110);
    iir_rd_i = 1'b1; tick(); iir_rd_i = 1'b0;
    lsr_rd_i = 1'b1; tick(); lsr_rd_i = 1'b0;
    chk_iir("thre_survives_rd", 4'b0010);
    thr_wr_i = 1'b1; tick(); thr_wr_i = 1'b0;
    chk_iir("thre_thr_wr_ack", 4'b0001);
    ier_i = 3'b101; tick();
    chk_iir("thre_ier_off", 4'b0001);
    ier_i = 3'b111; tick();
    chk_iir("thre_ier_rise", 4'b0010);
    tx_fifo_empty_i = 1'b0; tick();
    chk_iir("thre_pend_to_busy", 4'b0001);
  endtask

  task automatic test_rst_mid_pend();
    tx_fifo_empty_i = 1'b1; tick();
    chk_iir("pend_before_rst", 4'b0010);
    rx_bi_i = 1'b1; tick(); rx_bi_i = 1'b0;
    tx_fifo_empty_i = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({iir_o, intr_o, lsr_err_o, timeout_o} !== {4'b0001, 1'b0, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_pend: iir=%b intr=%b lsr=%b to=%b, required 0001 0 0000 0",
               iir_o, intr_o, lsr_err_o, timeout_o);
    end else $display("ok   rst_mid_pend reset values");
    tick();
    chk_iir("rst_no_residual", 4'b0001);
  endtask

`ifdef UART_CHAR_TIMEOUT_EN
  task automatic test_timeout();
    wls_i = 2'b11; pen_i = 1'b0; stb_i = 1'b0; ier_i = 3'b111;
    rx_fifo_empty_i = 1'b0; rx_push_i = 1'b1; tick(); rx_push_i = 1'b0;
    baud_ticks(639);
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL cti_639: timeout_o=%b required 0", timeout_o);
    end else $display("ok   cti_639: timeout_o=0");
    chk_iir("cti_639_iir", 4'b0001);
    baud_ticks(1);
    n_checks++;
    if (timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL cti_640: timeout_o=%b required 1", timeout_o);
    end else $display("ok   cti_640: timeout_o=1");
    chk_iir("cti_640_iir", 4'b1100);
    baud_ticks(5);
    chk_iir("cti_saturated", 4'b1100);
    rx_pop_i = 1'b1; tick(); rx_pop_i = 1'b0;
    chk_iir("cti_pop_clear", 4'b0001);
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL cti_pop_to: timeout_o=%b required 0", timeout_o);
    end else $display("ok   cti_pop_to: timeout_o=0");
  endtask

  task automatic test_rst_mid_count();
    baud_ticks(300);
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({iir_o, intr_o, lsr_err_o, timeout_o} !== {4'b0001, 1'b0, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_count: iir=%b intr=%b lsr=%b to=%b, required 0001 0 0000 0",
               iir_o, intr_o, lsr_err_o, timeout_o);
    end else $display("ok   rst_mid_count reset values");
    baud_ticks(639);
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL cnt_restart_639: timeout_o=%b required 0", timeout_o);
    end else $display("ok   cnt_restart_639: timeout_o=0");
    baud_ticks(1);
    chk_iir("cnt_restart_640", 4'b1100);
    rx_fifo_empty_i = 1'b1; tick();
    chk_iir("cti_empty_clear", 4'b0001);
  endtask
`else
  task automatic test_timeout();
    ier_i = 3'b111; rx_fifo_empty_i = 1'b0;
    rx_push_i = 1'b1; tick(); rx_push_i = 1'b0;
    baud_ticks(800);
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL cti_disabled: timeout_o=%b required 0", timeout_o);
    end else $display("ok   cti_disabled: timeout_o=0");
    chk_iir("cti_disabled_iir", 4'b0001);
    rx_fifo_empty_i = 1'b1; tick();
  endtask

  task automatic test_rst_mid_count();
    rx_fifo_empty_i = 1'b0; baud_ticks(300);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_iir("rst_mid_count_disabled", 4'b0001);
    rx_fifo_empty_i = 1'b1; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_rls();
    test_rls_over_rda();
    test_set_wins();
    test_thre();
    test_rst_mid_pend();
    test_timeout();
    test_rst_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
